// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Main control FSM for a multicycle RV32-style datapath. It walks each
//   instruction through FETCH/DECODE and then the load, store, ALU, branch or
//   jal sequence. It drives the datapath selects and the write strobes for
//   every state.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (state -> FETCH, strobes low)
//   instr       instruction register contents, valid from DECODE onward
//   Zero        ALU zero flag, used by beq/bne in BRANCH
//   mem_ready   memory handshake; an access completes in the cycle it is high
//   PCWrite     PC load enable
//   AdrSrc      memory address select: 0 = PC, 1 = ALU result register
//   MemWrite    data memory write strobe
//   IRWrite     instruction register load enable
//   RegWrite    register file write enable
//   ResultSrc   00 ALUOut reg, 01 memory data, 10 ALU result direct
//   ALUSrcA     00 PC, 01 old PC, 10 rs1
//   ALUSrcB     00 rs2, 01 immediate, 10 constant 4
//   ALUControl  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//   ImmSrc      00 I, 01 S, 10 B, 11 J
//   illegal     high while the FSM is parked in TRAP
module multicycle_control_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [2:0]            ALUControl,
    output logic [1:0]            ImmSrc,
    output logic                  illegal
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t     state, next_state;
    state_t     ill_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       is_store;
    logic       unused_instr_bits;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7_5 = instr[30];
    assign is_store = (opcode == OP_STORE);

    // Register indices and immediates are consumed by the datapath, not here.
    assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

    // An illegal encoding either parks the FSM or is dropped as a NOP.
    assign ill_state = TRAP_ILLEGAL ? TRAP : FETCH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        ImmSrc     = 2'b00;
        illegal    = 1'b0;

        case (state)
            FETCH: begin
                // PC + 4 goes straight back to the PC as the fetch completes.
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                // Branch target precomputed from old PC + B-immediate.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    default:           next_state = ill_state;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = is_store ? 2'b01 : 2'b00;
                if (funct3 != 3'b010) next_state = ill_state;
                else if (is_store)    next_state = MEMWRITE;
                else                  next_state = MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                next_state = ALUWB;
                case (funct3)
                    3'b000:  ALUControl = funct7_5 ? 3'b001 : 3'b000;
                    3'b111:  ALUControl = 3'b010;
                    3'b110:  ALUControl = 3'b011;
                    3'b100:  ALUControl = 3'b100;
                    3'b010:  ALUControl = 3'b101;
                    default: next_state = ill_state;
                endcase
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = ALUWB;
                case (funct3)
                    3'b000:  ALUControl = 3'b000;
                    3'b111:  ALUControl = 3'b010;
                    3'b110:  ALUControl = 3'b011;
                    3'b100:  ALUControl = 3'b100;
                    3'b010:  ALUControl = 3'b101;
                    default: next_state = ill_state;
                endcase
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                // rs1 - rs2 sets Zero; ALUOut already holds the target.
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                next_state = FETCH;
                case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = ~Zero;
                    default: next_state = ill_state;
                endcase
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ImmSrc     = 2'b11;
                PCWrite    = 1'b1;
                next_state = ALUWB;
            end
            TRAP: begin
                illegal    = 1'b1;
                next_state = TRAP;
            end
            default: next_state = FETCH;
        endcase

        // While reset is held the state is FETCH, whose strobes follow
        // mem_ready; force every strobe low so nothing is written.
        if (rst) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        mem_ready;

    logic       pcw1, adr1, mw1, irw1, rw1, ill1;
    logic [1:0] rs1, sa1, sb1, imm1;
    logic [2:0] alu1;
    logic       pcw2, adr2, mw2, irw2, rw2, ill2;
    logic [1:0] rs2, sa2, sb2, imm2;
    logic [2:0] alu2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.DATA_WIDTH(32), .TRAP_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1),
        .RegWrite(rw1), .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1),
        .ALUControl(alu1), .ImmSrc(imm1), .illegal(ill1)
    );

    multicycle_control_unit #(.DATA_WIDTH(32), .TRAP_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2),
        .RegWrite(rw2), .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2),
        .ALUControl(alu2), .ImmSrc(imm2), .illegal(ill2)
    );

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,illegal}
    logic [16:0] obs1, obs2;
    assign obs1 = {pcw1, adr1, mw1, irw1, rw1, rs1, sa1, sb1, alu1, imm1, ill1};
    assign obs2 = {pcw2, adr2, mw2, irw2, rw2, rs2, sa2, sb2, alu2, imm2, ill2};

    function automatic logic [16:0] ov(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [2:0] alu,
                                       input logic [1:0] imm,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check both DUTs mid-cycle, advance.
    task automatic cyc2(input string tag, input logic mr, input logic z,
                        input logic [16:0] e1, input logic [16:0] e2);
        mem_ready = mr;
        Zero      = z;
        @(negedge clk);
        check(tag, {15'd0, obs1}, {15'd0, e1});
        check({tag, "_nop"}, {15'd0, obs2}, {15'd0, e2});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic mr, input logic z, input logic [16:0] e);
        cyc2(tag, mr, z, e, e);
    endtask

    logic [16:0] V_RST, V_F1, V_DEC, V_MADL, V_MADS, V_MRD, V_MWB, V_MWR;
    logic [16:0] V_EXI, V_AWB, V_BR1, V_BR0, V_JAL, V_TRAP;

    initial begin
        V_RST  = ov(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
        V_F1   = ov(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
        V_DEC  = ov(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0);
        V_MADL = ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0);
        V_MADS = ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0);
        V_MRD  = ov(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        V_MWB  = ov(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        V_MWR  = ov(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        V_EXI  = ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0);
        V_AWB  = ov(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        V_BR1  = ov(1,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0);
        V_BR0  = ov(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0);
        V_JAL  = ov(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0);
        V_TRAP = ov(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);

        rst = 1'b1; instr = 32'h0; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("reset", {15'd0, obs1}, {15'd0, V_RST});
        check("reset_nop", {15'd0, obs2}, {15'd0, V_RST});
        @(posedge clk); #1;
        rst = 1'b0;

        // fetch stalls while memory is not ready
        instr = 32'h00A00093;              // addi x1,x0,10
        cyc("fetch_wait", 0, 0, V_RST);
        cyc("addi_f",  1, 0, V_F1);
        cyc("addi_d",  1, 0, V_DEC);
        cyc("addi_x",  1, 0, V_EXI);
        cyc("addi_wb", 1, 0, V_AWB);

        // lw with two wait cycles in MEMREAD: 7 cycles total
        instr = 32'h00012083;              // lw x1,0(x2)
        cyc("lw_f",   1, 0, V_F1);
        cyc("lw_d",   1, 0, V_DEC);
        cyc("lw_ma",  1, 0, V_MADL);
        cyc("lw_rd0", 0, 0, V_MRD);
        cyc("lw_rd1", 0, 0, V_MRD);
        cyc("lw_rd2", 1, 0, V_MRD);
        cyc("lw_wb",  1, 0, V_MWB);

        // sw with one wait cycle: MemWrite two cycles
        instr = 32'h00112023;              // sw x1,0(x2)
        cyc("sw_f",   1, 0, V_F1);
        cyc("sw_d",   1, 0, V_DEC);
        cyc("sw_ma",  1, 0, V_MADS);
        cyc("sw_wr0", 0, 0, V_MWR);
        cyc("sw_wr1", 1, 0, V_MWR);

        // beq taken / not taken
        instr = 32'h00000063;
        cyc("beq_f",  1, 0, V_F1);
        cyc("beq_d",  1, 0, V_DEC);
        cyc("beq_z1", 1, 1, V_BR1);
        cyc("beq_f2", 1, 0, V_F1);
        cyc("beq_d2", 1, 0, V_DEC);
        cyc("beq_z0", 1, 0, V_BR0);

        // bne not taken / taken
        instr = 32'h00001063;
        cyc("bne_f",  1, 0, V_F1);
        cyc("bne_d",  1, 0, V_DEC);
        cyc("bne_z1", 1, 1, V_BR0);
        cyc("bne_f2", 1, 0, V_F1);
        cyc("bne_d2", 1, 0, V_DEC);
        cyc("bne_z0", 1, 0, V_BR1);

        // R-type: sub and slt
        instr = 32'h402081B3;              // sub x3,x1,x2
        cyc("sub_f",  1, 0, V_F1);
        cyc("sub_d",  1, 0, V_DEC);
        cyc("sub_x",  1, 0, ov(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0));
        cyc("sub_wb", 1, 0, V_AWB);
        instr = 32'h0020A1B3;              // slt x3,x1,x2
        cyc("slt_f",  1, 0, V_F1);
        cyc("slt_d",  1, 0, V_DEC);
        cyc("slt_x",  1, 0, ov(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 0));
        cyc("slt_wb", 1, 0, V_AWB);

        // jal
        instr = 32'h000000EF;
        cyc("jal_f",  1, 0, V_F1);
        cyc("jal_d",  1, 0, V_DEC);
        cyc("jal_j",  1, 0, V_JAL);
        cyc("jal_wb", 1, 0, V_AWB);

        // reset during a stalled MEMWRITE drops MemWrite immediately
        instr = 32'h00112023;
        cyc("swr_f",  1, 0, V_F1);
        cyc("swr_d",  1, 0, V_DEC);
        cyc("swr_ma", 1, 0, V_MADS);
        mem_ready = 1'b0;
        @(negedge clk);
        check("swr_wr", {15'd0, obs1}, {15'd0, V_MWR});
        #1 rst = 1'b1;
        #1;
        check("swr_rst", {15'd0, obs1}, {15'd0, V_RST});
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("swr_post", 1, 0, V_F1);

        // illegal opcode: trap forever vs. NOP back to FETCH
        instr = 32'h0000007F;
        cyc("ill_d0", 1, 0, V_DEC);
        cyc2("ill_t1", 0, 0, V_TRAP, V_RST);
        cyc2("ill_t2", 0, 0, V_TRAP, V_RST);
        cyc2("ill_t3", 1, 0, V_TRAP, V_F1);

        // reset out of TRAP
        rst = 1'b1;
        #1;
        check("trap_rst", {15'd0, obs1}, {15'd0, V_RST});
        check("trap_rst_nop", {15'd0, obs2}, {15'd0, V_RST});
        @(posedge clk); #1;
        rst = 1'b0;

        // illegal funct3 on an I-type (slli) traps after EXECI
        instr = 32'h00101093;
        cyc("slli_f", 1, 0, V_F1);
        cyc("slli_d", 1, 0, V_DEC);
        cyc("slli_x", 1, 0, V_EXI);
        cyc2("slli_t", 0, 0, V_TRAP, V_RST);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of instr.
REQ-002 Parameter TRAP_ILLEGAL, default 1; 1 = illegal opcode/funct3 parks FSM in TRAP, 0 = treated as NOP.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 instr  in  DATA_WIDTH  instruction register contents (valid from DECODE onward).
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-008 PCWrite  out  1  PC load enable.
REQ-009 AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register.
REQ-010 MemWrite  out  1  data memory write strobe.
REQ-011 IRWrite  out  1  instruction register load enable.
REQ-012 RegWrite  out  1  register file write enable.
REQ-013 ResultSrc  out  2  00 ALUOut reg, 01 memory data, 10 ALU result direct.
REQ-014 ALUSrcA  out  2  00 PC, 01 old PC, 10 rs1.
REQ-015 ALUSrcB  out  2  00 rs2, 01 immediate, 10 constant 4.
REQ-016 ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-017 ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
REQ-018 illegal  out  1  high while FSM is in TRAP.

Function
REQ-019 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
REQ-020 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay until mem_ready=1, then DECODE.
REQ-021 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUControl=000 (branch target precompute); next by instr[6:0]: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, other -> illegal handling.
REQ-022 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=000, ImmSrc=00 for load, 01 for store; next MEMREAD (load) or MEMWRITE (store); funct3 other than 010 is illegal.
REQ-023 MEMREAD: AdrSrc=1; hold until mem_ready, then MEMWB. MEMWB: ResultSrc=01, RegWrite=1, next FETCH.
REQ-024 MEMWRITE: AdrSrc=1, MemWrite=1; hold until mem_ready, then FETCH; MemWrite stays high while waiting.
REQ-025 EXECR: ALUSrcA=10, ALUSrcB=00; funct3/funct7[5]: 000/0 add, 000/1 sub, 111 and, 110 or, 100 xor, 010 slt; else illegal; next ALUWB.
REQ-026 EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00; funct3 000 add, 111 and, 110 or, 100 xor, 010 slt; else illegal; next ALUWB.
REQ-027 ALUWB: ResultSrc=00, RegWrite=1, next FETCH.
REQ-028 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=001, ResultSrc=00; PCWrite=Zero for funct3 000, ~Zero for 001; other funct3 illegal; next FETCH.
REQ-029 JAL: ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=00, PCWrite=1, ImmSrc=11; next ALUWB.
REQ-030 Illegal: TRAP_ILLEGAL=1 -> TRAP, absorbing until reset, all enables 0; TRAP_ILLEGAL=0 -> FETCH, no enable asserted.
REQ-031 Outside listed cases every enable SHALL be 0 and every select 0; outputs are combinational of state (plus Zero, mem_ready, instr).
REQ-032 CPI: ALU 4, load 5, store 4, branch 3, jal 4 cycles, each memory state +1 per mem_ready-low cycle.

Reset
REQ-033 rst high SHALL force state to FETCH immediately and hold PCWrite, IRWrite, MemWrite, RegWrite, illegal at 0 regardless of mem_ready.
REQ-034 Reset mid-operation (any state, including TRAP or a pending MEMWRITE) SHALL abort the instruction with no further write strobes; first post-reset cycle is FETCH.

Verification
REQ-035 instr=0x00A00093 (addi x1,x0,10), mem_ready=1 -> FETCH,DECODE,EXECI,ALUWB; RegWrite=1 only in 4th cycle, ALUControl=000.
REQ-036 lw, mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles, AdrSrc=1, MEMWB RegWrite=1 ResultSrc=01, total 7 cycles.
REQ-037 sw, mem_ready low 1 cycle -> MemWrite=1 for 2 consecutive cycles, ImmSrc=01 in MEMADR, RegWrite never 1.
REQ-038 beq with Zero=1 then Zero=0; bne same -> PCWrite in BRANCH = 1,0 for beq and 0,1 for bne.
REQ-039 opcode 0x7F with TRAP_ILLEGAL=1 -> illegal=1 from cycle 3 indefinitely; TRAP_ILLEGAL=0 -> back to FETCH, no enables.
REQ-040 rst asserted mid-MEMWRITE with mem_ready=0 -> MemWrite drops same cycle, FETCH after release.
